multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU control decoder.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback over several clocks.
- Drives the shared datapath (one ALU, one unified memory, IR, PC) and stalls on a memory ready handshake.
- Adds illegal-opcode/funct detection and an instruction-done strobe.

Parameters:
- OPCODE_W, 4, opcode field width.
- FUNCT_W, 4, funct field width.
- ALU_OP_W, 4, ALU operation code width.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  from IR; valid from DECODE onward.
- funct  in  FUNCT_W  from IR.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  0=ALU result (PC+2), 1=branch target reg, 2=jump target.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  0=memory address from PC, 1=from ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  writeback data select (1=memory).
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=const 2, 2=sign-ext imm, 3=imm<<1.
- alu_op  out  ALU_OP_W  ALU operation.
- instr_done  out  1  one-cycle pulse in an instruction's final state.
- illegal_op  out  1  sticky; set on an undefined opcode/funct.
- cycle_cnt  out  CNT_W  perf counter (optional feature).
- instr_cnt  out  CNT_W  perf counter (optional feature).

Behaviour:
- Opcodes: 0 R-type, 1 LW, 2 SW, 3 ADDI, 4 BEQ, 5 BNE, 6 JMP; 7..max illegal.
- R-type funct 0..3 map to alu_op 0 ADD, 1 SUB, 2 AND, 3 OR; any other funct is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP.
- Outputs are decoded from the state register plus opcode/funct captured at DECODE; unlisted outputs are 0.
- Reset (async, any time, including mid-MEM) forces state=FETCH and all outputs to 0 immediately.
  - Counters clear to 0; illegal_op clears.
  - The first FETCH begins on the first clock after rst_n deasserts.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALU out); capture opcode/funct.
  - R/LW/SW/ADDI -> EXEC. BEQ/BNE -> BRANCH. Illegal -> TRAP.
  - JMP: pc_write=1, pc_src=2, instr_done=1; next state FETCH.
- EXEC:
  - Outputs: alu_src_a=1.
  - R-type: alu_src_b=0, alu_op from funct.
  - LW/SW/ADDI: alu_src_b=2, alu_op=ADD.
  - R/ADDI -> WB; LW/SW -> MEM.
- MEM:
  - Outputs: i_or_d=1; mem_read=1 for LW, mem_write=1 for SW.
  - Request held stable until mem_ready=1.
  - LW -> WB. SW asserts instr_done -> FETCH.
- WB: reg_write=1, mem_to_reg=(LW); instr_done=1; next state FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_write = BEQ&alu_zero | BNE&~alu_zero; instr_done=1; next state FETCH.
- TRAP: illegal_op=1; no PC, register or memory writes; remains in TRAP until reset.
- Latency with mem_ready always 1: JMP 2, BEQ/BNE 3, R/ADDI/SW 4, LW 5 cycles.
- Each mem_ready-low cycle in FETCH or MEM adds one cycle.
- mem_ready is ignored in all states other than FETCH and MEM.
- mem_read and mem_write are never both 1.
- reg_write and mem_write are never both 1.

Optional Feature:
- Macro MCU_PERF_COUNTERS_EN.
- Defined:
  - cycle_cnt increments every clock outside reset and TRAP.
  - instr_cnt increments on each instr_done.
  - Both wrap modulo 2^CNT_W.
- Undefined: no counter flops; cycle_cnt and instr_cnt tied to 0.

Decomposition:
- Package mcu_pkg holds:
  - state enum;
  - opcode constants OP_RTYPE..OP_JMP;
  - funct and ALU_OP codes;
  - pc_src and alu_src_b encodings.
- One sub-module, alu_op_decoder: combinational mapping of opcode/funct/state to alu_op plus a funct-illegal flag.

Test Plan:
- Reset then R-type ADD (opcode 0, funct 0), mem_ready=1: states F,D,E,W; reg_write=1 in cycle 4 only; instr_done in cycle 4.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM: completes in 10 cycles; mem_read held continuously during each wait.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in cycle 3. BNE with alu_zero=1 -> pc_write=0. Both take 3 cycles.
- JMP: pc_write=1, pc_src=2 in DECODE; next FETCH at cycle 3.
- Opcode 9, and separately R-type funct 7: TRAP entered, illegal_op=1 sticky, no write enables for 20 cycles; rst_n low clears to FETCH.
- rst_n asserted mid-MEM of SW: mem_write drops in the same cycle (async); restart in FETCH. With MCU_PERF_COUNTERS_EN, counters read 0 after reset and instr_cnt=3 after three instructions.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states,
// opcode/funct/ALU codes, PC and ALU-B source selects, and the control bundle.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_LW    = 1;
  localparam int unsigned OP_SW    = 2;
  localparam int unsigned OP_ADDI  = 3;
  localparam int unsigned OP_BEQ   = 4;
  localparam int unsigned OP_BNE   = 5;
  localparam int unsigned OP_JMP   = 6;

  localparam int unsigned FUNCT_ADD = 0;
  localparam int unsigned FUNCT_SUB = 1;
  localparam int unsigned FUNCT_AND = 2;
  localparam int unsigned FUNCT_OR  = 3;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ALUB_RT       = 2'd0,
    ALUB_CONST2   = 2'd1,
    ALUB_SIGN_IMM = 2'd2,
    ALUB_IMM_SHL1 = 2'd3
  } alu_src_b_e;

  // Datapath control bundle, excluding the parameter-width ALU op.
  typedef struct packed {
    logic       pc_write;
    pc_src_e    pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation select from state and opcode/funct, plus a flag
// for R-type funct values outside the supported set.
module alu_op_decoder
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNCT_W  = 4,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [2:0]          state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                funct_illegal
);

  logic is_rtype;

  assign is_rtype      = (opcode == OPCODE_W'(OP_RTYPE));
  assign funct_illegal = is_rtype && (funct > FUNCT_W'(FUNCT_OR));

  // Address/PC arithmetic is ADD everywhere except branch compare and R-type execute.
  always_comb begin
    alu_op = ALU_OP_W'(ALU_ADD);
    if (state == S_BRANCH) begin
      alu_op = ALU_OP_W'(ALU_SUB);
    end else if ((state == S_EXEC) && is_rtype) begin
      case (funct)
        FUNCT_W'(FUNCT_ADD): alu_op = ALU_OP_W'(ALU_ADD);
        FUNCT_W'(FUNCT_SUB): alu_op = ALU_OP_W'(ALU_SUB);
        FUNCT_W'(FUNCT_AND): alu_op = ALU_OP_W'(ALU_AND);
        FUNCT_W'(FUNCT_OR):  alu_op = ALU_OP_W'(ALU_OR);
        default:             alu_op = ALU_OP_W'(ALU_ADD);
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM (fetch/decode/execute/memory/writeback) with
// memory-ready stalls and illegal-instruction trap. Define MCU_PERF_COUNTERS_EN
// to add cycle and retired-instruction counters.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNCT_W  = 4,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  state_e              state_q, state_d;
  logic                active_q;
  logic                illegal_q;
  logic [OPCODE_W-1:0] opcode_q, dec_opcode;
  logic [FUNCT_W-1:0]  funct_q, dec_funct;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                funct_illegal, op_illegal;
  logic                is_rtype, is_lw, is_sw, is_addi, is_beq, is_bne, is_jmp;
  ctrl_t               ctrl;

  // DECODE sees the live IR fields; later states use the copy captured there.
  assign dec_opcode = (state_q == S_DECODE) ? opcode : opcode_q;
  assign dec_funct  = (state_q == S_DECODE) ? funct  : funct_q;

  assign is_rtype = (dec_opcode == OPCODE_W'(OP_RTYPE));
  assign is_lw    = (dec_opcode == OPCODE_W'(OP_LW));
  assign is_sw    = (dec_opcode == OPCODE_W'(OP_SW));
  assign is_addi  = (dec_opcode == OPCODE_W'(OP_ADDI));
  assign is_beq   = (dec_opcode == OPCODE_W'(OP_BEQ));
  assign is_bne   = (dec_opcode == OPCODE_W'(OP_BNE));
  assign is_jmp   = (dec_opcode == OPCODE_W'(OP_JMP));

  assign op_illegal = !(is_rtype | is_lw | is_sw | is_addi | is_beq | is_bne | is_jmp)
                      | funct_illegal;

  alu_op_decoder #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_op_decoder (
    .state         (state_q),
    .opcode        (dec_opcode),
    .funct         (dec_funct),
    .alu_op        (dec_alu_op),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // active_q holds the FSM idle until the first clock after reset release.
  always_comb begin
    state_d = state_q;
    if (active_q) begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          if (op_illegal)            state_d = S_TRAP;
          else if (is_jmp)           state_d = S_FETCH;
          else if (is_beq || is_bne) state_d = S_BRANCH;
          else                       state_d = S_EXEC;
        end
        S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
        S_MEM:    if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
        S_WB:     state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALUB_CONST2;
          if (mem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_ALU;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_b = ALUB_IMM_SHL1;
          if (is_jmp) begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = PC_SRC_JUMP;
            ctrl.instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = is_rtype ? ALUB_RT : ALUB_SIGN_IMM;
        end
        S_MEM: begin
          ctrl.i_or_d     = 1'b1;
          ctrl.mem_read   = is_lw;
          ctrl.mem_write  = is_sw;
          ctrl.instr_done = is_sw && mem_ready;
        end
        S_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = is_lw;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = ALUB_RT;
          ctrl.pc_src     = PC_SRC_BRANCH;
          ctrl.pc_write   = (is_beq && alu_zero) || (is_bne && !alu_zero);
          ctrl.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      opcode_q  <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign instr_done = ctrl.instr_done;
  assign alu_op     = active_q ? dec_alu_op : '0;
  assign illegal_op = illegal_q;

`ifdef MCU_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q, instr_q;

  // Free-running perf counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (active_q && (state_q != S_TRAP)) cycle_q <= cycle_q + CNT_W'(1);
      if (ctrl.instr_done)                  instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a driver issues instructions and
// queues per-instruction expectations; a monitor checks them on instr_done.
module tb_multicycle_control_unit;

`ifdef MCU_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode, funct;
  logic        alu_zero, mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op;
  logic [31:0] cycle_cnt, instr_cnt;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int opc; int fn; int fw; int mw; int z; } instr_t;
  typedef struct {
    int lat; int pcw; int pcsrc; int rw; int rwcyc; int m2r;
    int mw_cnt; int mr_cnt; int iod_cnt; int chk_ex; int ex_op; int ex_b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;
  int   n_instr, cyc_sum;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int outs();
    return int'({pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op});
  endfunction

  // Reference model: per-instruction totals from the instruction-level rules.
  function automatic exp_t model(input instr_t t);
    exp_t e;
    int base;
    bit mem_op = (t.opc == 1) || (t.opc == 2);
    bit br     = (t.opc == 4) || (t.opc == 5);
    bit taken  = ((t.opc == 4) && (t.z != 0)) || ((t.opc == 5) && (t.z == 0));
    bit wr_reg = (t.opc == 0) || (t.opc == 1) || (t.opc == 3);
    case (t.opc)
      6:       base = 2;
      4, 5:    base = 3;
      1:       base = 5;
      default: base = 4;
    endcase
    e.lat     = base + t.fw + (mem_op ? t.mw : 0);
    e.pcw     = 1 + ((t.opc == 6) ? 1 : 0) + (taken ? 1 : 0);
    e.pcsrc   = (t.opc == 6) ? 2 : (taken ? 1 : 0);
    e.rw      = wr_reg ? 1 : 0;
    e.rwcyc   = wr_reg ? e.lat : 0;
    e.m2r     = (t.opc == 1) ? 1 : 0;
    e.mw_cnt  = (t.opc == 2) ? t.mw + 1 : 0;
    e.mr_cnt  = t.fw + 1 + ((t.opc == 1) ? t.mw + 1 : 0);
    e.iod_cnt = mem_op ? t.mw + 1 : 0;
    e.chk_ex  = (t.opc != 6) ? 1 : 0;
    e.ex_op   = (t.opc == 0) ? t.fn : (br ? 1 : 0);
    e.ex_b    = ((t.opc == 0) || br) ? 0 : 2;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input instr_t t);
    exp_t e = model(t);
    sb_q.push_back(e);
    n_instr++;
    cyc_sum += e.lat;
    opcode   = 4'(t.opc);
    funct    = 4'(t.fn);
    alu_zero = (t.z != 0);
    for (int i = 0; i < t.fw; i++) begin mem_ready = 1'b0; tick(); end
    mem_ready = 1'b1; tick();
    if ((t.opc == 1) || (t.opc == 2)) begin
      mem_ready = 1'($urandom); tick();
      mem_ready = 1'($urandom); tick();
      for (int i = 0; i < t.mw; i++) begin mem_ready = 1'b0; tick(); end
      mem_ready = 1'b1; tick();
      if (t.opc == 1) begin mem_ready = 1'($urandom); tick(); end
    end else begin
      for (int i = 0; i < e.lat - t.fw - 1; i++) begin mem_ready = 1'($urandom); tick(); end
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t.opc = int'($urandom_range(0, 6));
    t.fn  = (t.opc == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
    t.fw  = int'($urandom_range(0, 2));
    t.mw  = int'($urandom_range(0, 3));
    t.z   = int'($urandom_range(0, 1));
    return t;
  endfunction

  // Leaves the bench 1ns into the first active (FETCH) cycle.
  task automatic do_reset();
    mon_en    = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("release_idle_outputs", outs(), 0);
    tick();
    chk("cycle_cnt_after_reset", int'(cycle_cnt), 0);
    chk("instr_cnt_after_reset", int'(instr_cnt), 0);
    n_instr = 0;
    cyc_sum = 0;
  endtask

  // Monitor state
  int   cyc, m_rd, m_wr, m_iod, m_pcw, m_pcsrc, m_rw, m_rwcyc, m_m2r, m_irw;
  int   k, m_dec_a, m_dec_b, m_dec_op, m_ex_a, m_ex_b, m_ex_op;
  bit   seen_ir;
  exp_t e_mon;

  task automatic clear_acc();
    cyc = 0; m_rd = 0; m_wr = 0; m_iod = 0; m_pcw = 0; m_pcsrc = 0;
    m_rw = 0; m_rwcyc = 0; m_m2r = 0; m_irw = 0; k = 0; seen_ir = 1'b0;
    m_dec_a = -1; m_dec_b = -1; m_dec_op = -1; m_ex_a = -1; m_ex_b = -1; m_ex_op = -1;
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      clear_acc();
    end else begin
      cyc++;
      chk("rd_wr_exclusive", int'(mem_read & mem_write), 0);
      chk("regwr_memwr_exclusive", int'(reg_write & mem_write), 0);
      if (mem_read)  m_rd++;
      if (mem_write) m_wr++;
      if (i_or_d)    m_iod++;
      if (pc_write) begin m_pcw++; m_pcsrc = int'(pc_src); end
      if (reg_write) begin m_rw++; m_rwcyc = cyc; m_m2r = int'(mem_to_reg); end
      if (ir_write) begin m_irw++; k = 0; seen_ir = 1'b1; end
      else if (seen_ir) k++;
      if (seen_ir && (k == 1)) begin
        m_dec_a = int'(alu_src_a); m_dec_b = int'(alu_src_b); m_dec_op = int'(alu_op);
      end
      if (seen_ir && (k == 2)) begin
        m_ex_a = int'(alu_src_a); m_ex_b = int'(alu_src_b); m_ex_op = int'(alu_op);
      end
      if (instr_done) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr_done: got done at cycle %0d, expected none queued", cyc);
        end else begin
          e_mon = sb_q.pop_front();
          chk("latency", cyc, e_mon.lat);
          chk("ir_write_count", m_irw, 1);
          chk("pc_write_count", m_pcw, e_mon.pcw);
          chk("last_pc_src", m_pcsrc, e_mon.pcsrc);
          chk("reg_write_count", m_rw, e_mon.rw);
          chk("reg_write_cycle", m_rwcyc, e_mon.rwcyc);
          chk("mem_to_reg", m_m2r, e_mon.m2r);
          chk("mem_write_cycles", m_wr, e_mon.mw_cnt);
          chk("mem_read_cycles", m_rd, e_mon.mr_cnt);
          chk("i_or_d_cycles", m_iod, e_mon.iod_cnt);
          chk("decode_alu_src_a", m_dec_a, 0);
          chk("decode_alu_src_b", m_dec_b, 3);
          chk("decode_alu_op", m_dec_op, 0);
          if (e_mon.chk_ex != 0) begin
            chk("exec_alu_src_a", m_ex_a, 1);
            chk("exec_alu_src_b", m_ex_b, e_mon.ex_b);
            chk("exec_alu_op", m_ex_op, e_mon.ex_op);
          end
        end
        clear_acc();
      end else if (cyc > 60) begin
        checks++; errors++;
        $display("FAIL instr_done_timeout: got %0d cycles without done, expected at most 60", cyc);
        if (sb_q.size() > 0) e_mon = sb_q.pop_front();
        clear_acc();
      end
    end
  end

  task automatic trap_test(input int opc, input int fn);
    do_reset();
    opcode = 4'(opc); funct = 4'(fn); mem_ready = 1'b1; alu_zero = 1'b0;
    chk("trap_fetch_mem_read", int'(mem_read), 1);
    tick();
    chk("trap_decode_illegal_low", int'(illegal_op), 0);
    chk("trap_decode_pc_write", int'(pc_write), 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("trap_illegal_sticky", int'(illegal_op), 1);
      chk("trap_no_writes", int'({pc_write, ir_write, reg_write, mem_write, mem_read, instr_done}), 0);
      mem_ready = 1'($urandom);
      opcode    = 4'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("trap_reset_clears_illegal", int'(illegal_op), 0);
    do_reset();
    chk("trap_restart_fetch", int'(mem_read), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    #3;
    do_reset();
    chk("first_fetch_mem_read", int'(mem_read), 1);
    chk("first_fetch_alu_src_b", int'(alu_src_b), 1);
    mon_en = 1'b1;
    run_instr('{0, 0, 0, 0, 0});
    run_instr('{1, 0, 2, 3, 0});
    run_instr('{4, 0, 0, 0, 1});
    chk("instr_cnt_after_3", int'(instr_cnt), PERF ? 3 : 0);
    chk("cycle_cnt_after_3", int'(cycle_cnt), PERF ? 17 : 0);
    run_instr('{5, 0, 0, 0, 1});
    run_instr('{6, 0, 0, 0, 0});
    for (int i = 0; i < 40; i++) run_instr(rand_instr());
    chk("instr_cnt_stream", int'(instr_cnt), PERF ? n_instr : 0);
    chk("cycle_cnt_stream", int'(cycle_cnt), PERF ? cyc_sum : 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    trap_test(9, 0);
    trap_test(0, 7);

    // Async reset in the middle of a stalled SW memory phase
    do_reset();
    opcode = 4'(2); funct = '0; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    chk("sw_mem_write_on", int'(mem_write), 1);
    tick();
    #3;
    chk("sw_mem_write_held", int'(mem_write), 1);
    chk("sw_mem_read_off", int'(mem_read), 0);
    chk("sw_i_or_d", int'(i_or_d), 1);
    rst_n = 1'b0;
    #1;
    chk("sw_reset_mem_write_drop", int'(mem_write), 0);
    chk("sw_reset_outputs", outs(), 0);
    do_reset();
    chk("restart_fetch_mem_read", int'(mem_read), 1);
    chk("restart_fetch_i_or_d", int'(i_or_d), 0);

    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) run_instr(rand_instr());
    chk("scoreboard_drained_2", sb_q.size(), 0);
    chk("instr_cnt_stream_2", int'(instr_cnt), PERF ? n_instr : 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
